// File: rtl/ex_stage.sv
// Execute stage of the RV32IM pipeline: ALU, shifts, compares, multiply, link,
// branch resolution and address generation. Defining EX_DIV_EN adds the iterative divider.
module ex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  aluop_i,
    input  logic [2:0]  alusel_i,
    input  logic [31:0] reg1_i,
    input  logic [31:0] reg2_i,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic [31:0] link_addr_i,
    input  logic [31:0] offset_i,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic [7:0]  mem_aluop_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_reg2_o,
    output logic        branch_flag_o,
    output logic [31:0] branch_target_o,
    output logic        stallreq_o
);

    // Result classes; loads/stores share the NOP class and are told apart by aluop.
    localparam logic [2:0] SEL_NOP    = 3'd0;
    localparam logic [2:0] SEL_LOGIC  = 3'd1;
    localparam logic [2:0] SEL_SHIFT  = 3'd2;
    localparam logic [2:0] SEL_ARITH  = 3'd3;
    localparam logic [2:0] SEL_MUL    = 3'd4;
    localparam logic [2:0] SEL_DIV    = 3'd5;
    localparam logic [2:0] SEL_JUMP   = 3'd6;
    localparam logic [2:0] SEL_BRANCH = 3'd7;

    localparam logic [7:0] OP_AND    = 8'h01;
    localparam logic [7:0] OP_OR     = 8'h02;
    localparam logic [7:0] OP_XOR    = 8'h03;
    localparam logic [7:0] OP_SLL    = 8'h04;
    localparam logic [7:0] OP_SRL    = 8'h05;
    localparam logic [7:0] OP_SRA    = 8'h06;
    localparam logic [7:0] OP_ADD    = 8'h07;
    localparam logic [7:0] OP_SUB    = 8'h08;
    localparam logic [7:0] OP_SLT    = 8'h09;
    localparam logic [7:0] OP_SLTU   = 8'h0A;
    localparam logic [7:0] OP_LUI    = 8'h0B;
    localparam logic [7:0] OP_AUIPC  = 8'h0C;
    localparam logic [7:0] OP_MUL    = 8'h10;
    localparam logic [7:0] OP_MULH   = 8'h11;
    localparam logic [7:0] OP_MULHSU = 8'h12;
    localparam logic [7:0] OP_MULHU  = 8'h13;
    localparam logic [7:0] OP_DIV    = 8'h14;
    localparam logic [7:0] OP_DIVU   = 8'h15;
    localparam logic [7:0] OP_REM    = 8'h16;
    localparam logic [7:0] OP_REMU   = 8'h17;
    localparam logic [7:0] OP_JAL    = 8'h18;
    localparam logic [7:0] OP_JALR   = 8'h19;
    localparam logic [7:0] OP_BEQ    = 8'h1A;
    localparam logic [7:0] OP_BNE    = 8'h1B;
    localparam logic [7:0] OP_BLT    = 8'h1C;
    localparam logic [7:0] OP_BGE    = 8'h1D;
    localparam logic [7:0] OP_BLTU   = 8'h1E;
    localparam logic [7:0] OP_BGEU   = 8'h1F;
    localparam logic [7:0] OP_LB     = 8'h20;
    localparam logic [7:0] OP_SW     = 8'h27;

    logic        lt_s;
    logic        ltu_s;
    logic [63:0] mul_a_s;
    logic [63:0] mul_b_s;
    logic [63:0] prod_s;
    logic [31:0] result_s;
    logic        keep_s;
    logic        taken_s;
    logic        div_stall_s;
    logic        div_valid_s;
    logic [31:0] div_result_s;

    assign lt_s  = $signed(reg1_i) < $signed(reg2_i);
    assign ltu_s = reg1_i < reg2_i;

    // Sign/zero-extend to 64 bits; the low 64 bits of the product are exact either way.
    assign mul_a_s = {{32{(aluop_i != OP_MULHU) & reg1_i[31]}}, reg1_i};
    assign mul_b_s = {{32{(aluop_i == OP_MULH) & reg2_i[31]}}, reg2_i};
    assign prod_s  = mul_a_s * mul_b_s;

`ifdef EX_DIV_EN
    typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_e;

    div_state_e  div_state_q, div_state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] quot_q, quot_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] divisor_q, divisor_d;
    logic        quot_neg_q, quot_neg_d;
    logic        rem_neg_q, rem_neg_d;
    logic        op_rem_q, op_rem_d;
    logic        is_div_op_s;
    logic        signed_op_s;
    logic        a_neg_s;
    logic        b_neg_s;
    logic [32:0] trial_s;
    logic [32:0] diff_s;

    assign is_div_op_s = (aluop_i == OP_DIV) || (aluop_i == OP_DIVU) ||
                         (aluop_i == OP_REM) || (aluop_i == OP_REMU);
    assign signed_op_s = (aluop_i == OP_DIV) || (aluop_i == OP_REM);
    assign a_neg_s     = signed_op_s & reg1_i[31];
    assign b_neg_s     = signed_op_s & reg2_i[31];
    assign trial_s     = {rem_q, quot_q[31]};
    assign diff_s      = trial_s - {1'b0, divisor_q};

    // Divider next-state: operand capture, restoring steps, sign-corrected result.
    always_comb begin
        div_state_d  = div_state_q;
        cnt_d        = cnt_q;
        quot_d       = quot_q;
        rem_d        = rem_q;
        divisor_d    = divisor_q;
        quot_neg_d   = quot_neg_q;
        rem_neg_d    = rem_neg_q;
        op_rem_d     = op_rem_q;
        div_stall_s  = 1'b0;
        div_valid_s  = 1'b0;
        div_result_s = 32'd0;
        case (div_state_q)
            DIV_IDLE: begin
                if ((alusel_i == SEL_DIV) && is_div_op_s) begin
                    div_stall_s = 1'b1;
                    op_rem_d    = (aluop_i == OP_REM) || (aluop_i == OP_REMU);
                    cnt_d       = 5'd0;
                    if (reg2_i == 32'd0) begin
                        quot_d      = 32'hFFFF_FFFF;
                        rem_d       = reg1_i;
                        divisor_d   = 32'd0;
                        quot_neg_d  = 1'b0;
                        rem_neg_d   = 1'b0;
                        div_state_d = DIV_DONE;
                    end else if (signed_op_s && (reg1_i == 32'h8000_0000) &&
                                 (reg2_i == 32'hFFFF_FFFF)) begin
                        quot_d      = 32'h8000_0000;
                        rem_d       = 32'd0;
                        divisor_d   = 32'd0;
                        quot_neg_d  = 1'b0;
                        rem_neg_d   = 1'b0;
                        div_state_d = DIV_DONE;
                    end else begin
                        quot_d      = a_neg_s ? (32'd0 - reg1_i) : reg1_i;
                        divisor_d   = b_neg_s ? (32'd0 - reg2_i) : reg2_i;
                        rem_d       = 32'd0;
                        quot_neg_d  = a_neg_s ^ b_neg_s;
                        rem_neg_d   = a_neg_s;
                        div_state_d = DIV_BUSY;
                    end
                end else begin
                    div_state_d = DIV_IDLE;
                end
            end
            DIV_BUSY: begin
                div_stall_s = 1'b1;
                // A borrow out of the trial subtraction means the divisor did not fit.
                quot_d = {quot_q[30:0], ~diff_s[32]};
                rem_d  = diff_s[32] ? trial_s[31:0] : diff_s[31:0];
                cnt_d  = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    div_state_d = DIV_DONE;
                end else begin
                    div_state_d = DIV_BUSY;
                end
            end
            DIV_DONE: begin
                div_valid_s = 1'b1;
                if (op_rem_q) begin
                    div_result_s = rem_neg_q ? (32'd0 - rem_q) : rem_q;
                end else begin
                    div_result_s = quot_neg_q ? (32'd0 - quot_q) : quot_q;
                end
                div_state_d = DIV_IDLE;
            end
            default: begin
                div_state_d = DIV_IDLE;
            end
        endcase
    end

    // Divider state and operand registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_state_q <= DIV_IDLE;
            cnt_q       <= 5'd0;
            quot_q      <= 32'd0;
            rem_q       <= 32'd0;
            divisor_q   <= 32'd0;
            quot_neg_q  <= 1'b0;
            rem_neg_q   <= 1'b0;
            op_rem_q    <= 1'b0;
        end else begin
            div_state_q <= div_state_d;
            cnt_q       <= cnt_d;
            quot_q      <= quot_d;
            rem_q       <= rem_d;
            divisor_q   <= divisor_d;
            quot_neg_q  <= quot_neg_d;
            rem_neg_q   <= rem_neg_d;
            op_rem_q    <= op_rem_d;
        end
    end
`else
    logic unused_clk_s;

    assign unused_clk_s = clk;
    assign div_stall_s  = 1'b0;
    assign div_valid_s  = 1'b0;
    assign div_result_s = 32'd0;
`endif

    // Per-class result selection and write-enable qualification.
    always_comb begin
        result_s = 32'd0;
        keep_s   = 1'b1;
        taken_s  = 1'b0;
        case (alusel_i)
            SEL_LOGIC: begin
                case (aluop_i)
                    OP_AND:  result_s = reg1_i & reg2_i;
                    OP_OR:   result_s = reg1_i | reg2_i;
                    OP_XOR:  result_s = reg1_i ^ reg2_i;
                    default: keep_s   = 1'b0;
                endcase
            end
            SEL_SHIFT: begin
                case (aluop_i)
                    OP_SLL:  result_s = reg1_i << reg2_i[4:0];
                    OP_SRL:  result_s = reg1_i >> reg2_i[4:0];
                    OP_SRA:  result_s = $unsigned($signed(reg1_i) >>> reg2_i[4:0]);
                    default: keep_s   = 1'b0;
                endcase
            end
            SEL_ARITH: begin
                case (aluop_i)
                    OP_ADD, OP_AUIPC: result_s = reg1_i + reg2_i;
                    OP_SUB:           result_s = reg1_i - reg2_i;
                    OP_SLT:           result_s = {31'd0, lt_s};
                    OP_SLTU:          result_s = {31'd0, ltu_s};
                    OP_LUI:           result_s = reg2_i;
                    default:          keep_s   = 1'b0;
                endcase
            end
            SEL_MUL: begin
                case (aluop_i)
                    OP_MUL:                        result_s = prod_s[31:0];
                    OP_MULH, OP_MULHSU, OP_MULHU:  result_s = prod_s[63:32];
                    default:                       keep_s   = 1'b0;
                endcase
            end
            SEL_DIV: begin
                result_s = div_result_s;
                keep_s   = div_valid_s;
            end
            SEL_JUMP: begin
                if ((aluop_i == OP_JAL) || (aluop_i == OP_JALR)) begin
                    result_s = link_addr_i;
                end else begin
                    keep_s = 1'b0;
                end
            end
            SEL_BRANCH: begin
                keep_s = 1'b0;
                case (aluop_i)
                    OP_BEQ:  taken_s = (reg1_i == reg2_i);
                    OP_BNE:  taken_s = (reg1_i != reg2_i);
                    OP_BLT:  taken_s = lt_s;
                    OP_BGE:  taken_s = ~lt_s;
                    OP_BLTU: taken_s = ltu_s;
                    OP_BGEU: taken_s = ~ltu_s;
                    default: taken_s = 1'b0;
                endcase
            end
            SEL_NOP: begin
                keep_s = (aluop_i >= OP_LB) && (aluop_i <= OP_SW);
            end
            default: begin
                keep_s = 1'b0;
            end
        endcase
    end

    // Output stage: everything reads zero while reset is held.
    always_comb begin
        if (rst) begin
            wd_o            = 5'd0;
            wreg_o          = 1'b0;
            wdata_o         = 32'd0;
            mem_aluop_o     = 8'd0;
            mem_addr_o      = 32'd0;
            mem_reg2_o      = 32'd0;
            branch_flag_o   = 1'b0;
            branch_target_o = 32'd0;
            stallreq_o      = 1'b0;
        end else begin
            wd_o            = wd_i;
            wreg_o          = wreg_i & keep_s;
            wdata_o         = result_s;
            mem_aluop_o     = aluop_i;
            mem_addr_o      = reg1_i + offset_i;
            mem_reg2_o      = reg2_i;
            branch_flag_o   = taken_s;
            branch_target_o = taken_s ? offset_i : 32'd0;
            stallreq_o      = div_stall_s;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage; divider scenarios run when EX_DIV_EN is defined,
// otherwise the DIV class is checked to behave as a NOP.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  aluop_i;
    logic [2:0]  alusel_i;
    logic [31:0] reg1_i, reg2_i, link_addr_i, offset_i;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o, mem_addr_o, mem_reg2_o, branch_target_o;
    logic [7:0]  mem_aluop_o;
    logic        branch_flag_o, stallreq_o;

    int errors = 0;
    int checks = 0;

    ex_stage dut (
        .clk(clk), .rst(rst), .aluop_i(aluop_i), .alusel_i(alusel_i),
        .reg1_i(reg1_i), .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i),
        .link_addr_i(link_addr_i), .offset_i(offset_i),
        .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .mem_aluop_o(mem_aluop_o),
        .mem_addr_o(mem_addr_o), .mem_reg2_o(mem_reg2_o), .branch_flag_o(branch_flag_o),
        .branch_target_o(branch_target_o), .stallreq_o(stallreq_o)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic [2:0] sel, input logic [7:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        alusel_i = sel;
        aluop_i  = op;
        reg1_i   = a;
        reg2_i   = b;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(3'd3, 8'h07, 32'h1234_5678, 32'h1111_1111);
        wd_i = 5'd9; wreg_i = 1'b1; offset_i = 32'h40; link_addr_i = 32'h8;
        @(posedge clk); @(posedge clk); #1;
        checks++; if (wdata_o !== 32'd0) begin errors++; $display("FAIL reset_wdata got=%h exp=0", wdata_o); end
        checks++; if (wreg_o !== 1'b0 || wd_o !== 5'd0) begin errors++; $display("FAIL reset_wreg got=%b/%0d exp=0/0", wreg_o, wd_o); end
        checks++; if (mem_addr_o !== 32'd0 || mem_aluop_o !== 8'd0 || stallreq_o !== 1'b0) begin
            errors++; $display("FAIL reset_mem got=%h/%h/%b exp=0", mem_addr_o, mem_aluop_o, stallreq_o); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_arith();
        drive(3'd3, 8'h07, 32'h7FFF_FFFF, 32'h1); wd_i = 5'd5; wreg_i = 1'b1; #1;
        checks++; if (wdata_o !== 32'h8000_0000) begin errors++; $display("FAIL add_wrap got=%h exp=80000000", wdata_o); end
        checks++; if (wd_o !== 5'd5 || wreg_o !== 1'b1) begin errors++; $display("FAIL add_wd got=%0d/%b exp=5/1", wd_o, wreg_o); end
        checks++; if (stallreq_o !== 1'b0) begin errors++; $display("FAIL add_stall got=%b exp=0", stallreq_o); end
        drive(3'd3, 8'h08, 32'h0, 32'h1); #1;
        checks++; if (wdata_o !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sub got=%h exp=ffffffff", wdata_o); end
        drive(3'd3, 8'h0A, 32'h1, 32'hFFFF_FFFF); #1;
        checks++; if (wdata_o !== 32'h1) begin errors++; $display("FAIL sltu got=%h exp=1", wdata_o); end
        drive(3'd3, 8'h09, 32'h1, 32'hFFFF_FFFF); #1;
        checks++; if (wdata_o !== 32'h0) begin errors++; $display("FAIL slt got=%h exp=0", wdata_o); end
    endtask

    task automatic test_logic_shift();
        drive(3'd1, 8'h03, 32'hA5A5_A5A5, 32'hFFFF_0000); #1;
        checks++; if (wdata_o !== 32'h5A5A_A5A5) begin errors++; $display("FAIL xor got=%h exp=5a5aa5a5", wdata_o); end
        drive(3'd2, 8'h06, 32'h8000_0000, 32'h24); #1;
        checks++; if (wdata_o !== 32'hF800_0000) begin errors++; $display("FAIL sra got=%h exp=f8000000", wdata_o); end
        drive(3'd2, 8'h05, 32'h8000_0000, 32'h24); #1;
        checks++; if (wdata_o !== 32'h0800_0000) begin errors++; $display("FAIL srl got=%h exp=08000000", wdata_o); end
    endtask

    task automatic test_mul();
        drive(3'd4, 8'h11, 32'h8000_0000, 32'h8000_0000); #1;
        checks++; if (wdata_o !== 32'h4000_0000) begin errors++; $display("FAIL mulh got=%h exp=40000000", wdata_o); end
        drive(3'd4, 8'h13, 32'hFFFF_FFFF, 32'hFFFF_FFFF); #1;
        checks++; if (wdata_o !== 32'hFFFF_FFFE) begin errors++; $display("FAIL mulhu got=%h exp=fffffffe", wdata_o); end
        drive(3'd4, 8'h12, 32'hFFFF_FFFF, 32'hFFFF_FFFF); #1;
        checks++; if (wdata_o !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mulhsu got=%h exp=ffffffff", wdata_o); end
        drive(3'd4, 8'h10, 32'h0001_0003, 32'h0000_0005); #1;
        checks++; if (wdata_o !== 32'h0005_000F) begin errors++; $display("FAIL mul_lo got=%h exp=0005000f", wdata_o); end
    endtask

    task automatic test_branch_jump_mem();
        drive(3'd7, 8'h1C, 32'hFFFF_FFFF, 32'h1); offset_i = 32'h100; wreg_i = 1'b1; #1;
        checks++; if (branch_flag_o !== 1'b1 || branch_target_o !== 32'h100) begin
            errors++; $display("FAIL blt got=%b/%h exp=1/100", branch_flag_o, branch_target_o); end
        checks++; if (wreg_o !== 1'b0) begin errors++; $display("FAIL blt_wreg got=%b exp=0", wreg_o); end
        drive(3'd7, 8'h1E, 32'hFFFF_FFFF, 32'h1); #1;
        checks++; if (branch_flag_o !== 1'b0) begin errors++; $display("FAIL bltu got=%b exp=0", branch_flag_o); end
        drive(3'd7, 8'h1F, 32'hFFFF_FFFF, 32'h1); #1;
        checks++; if (branch_flag_o !== 1'b1) begin errors++; $display("FAIL bgeu got=%b exp=1", branch_flag_o); end
        drive(3'd6, 8'h18, 32'h0, 32'h0); link_addr_i = 32'h1004; #1;
        checks++; if (wdata_o !== 32'h1004 || wreg_o !== 1'b1) begin errors++; $display("FAIL jal got=%h/%b exp=1004/1", wdata_o, wreg_o); end
        drive(3'd0, 8'h22, 32'h1000, 32'hCAFE_F00D); offset_i = 32'hFFFF_FFFC; #1;
        checks++; if (mem_addr_o !== 32'h0FFC || wdata_o !== 32'd0 || wreg_o !== 1'b1) begin
            errors++; $display("FAIL lw got=%h/%h/%b exp=ffc/0/1", mem_addr_o, wdata_o, wreg_o); end
        checks++; if (mem_reg2_o !== 32'hCAFE_F00D || mem_aluop_o !== 8'h22) begin
            errors++; $display("FAIL lw_fwd got=%h/%h exp=cafef00d/22", mem_reg2_o, mem_aluop_o); end
        drive(3'd0, 8'h00, 32'h5, 32'h6); #1;
        checks++; if (wreg_o !== 1'b0 || wdata_o !== 32'd0) begin errors++; $display("FAIL nop got=%b/%h exp=0/0", wreg_o, wdata_o); end
    endtask

`ifdef EX_DIV_EN
    // Presents a divide just after an edge and counts stall cycles until the result appears.
    task automatic run_div(input string name, input logic [7:0] op, input logic [31:0] a,
                           input logic [31:0] b, input int exp_stalls, input logic [31:0] exp_data);
        int  stalls = 0;
        bit  got = 1'b0;
        @(posedge clk); #1;
        drive(3'd5, op, a, b); wreg_i = 1'b1;
        for (int c = 0; c < 100; c++) begin
            #3;
            if (stallreq_o === 1'b1) begin
                stalls++;
                @(posedge clk); #1;
            end else begin
                got = 1'b1;
                break;
            end
        end
        checks++; if (!got || stalls != exp_stalls) begin errors++; $display("FAIL %s_stalls got=%0d exp=%0d", name, stalls, exp_stalls); end
        checks++; if (wdata_o !== exp_data || wreg_o !== 1'b1) begin
            errors++; $display("FAIL %s_data got=%h/%b exp=%h/1", name, wdata_o, wreg_o, exp_data); end
        @(posedge clk); #1;
        drive(3'd0, 8'h00, 32'h0, 32'h0);
    endtask

    task automatic test_div();
        run_div("div", 8'h14, 32'hFFFF_FFF9, 32'h2, 33, 32'hFFFF_FFFD);
        run_div("rem", 8'h16, 32'hFFFF_FFF9, 32'h2, 33, 32'hFFFF_FFFF);
        run_div("divu_zero", 8'h15, 32'h5, 32'h0, 1, 32'hFFFF_FFFF);
        run_div("rem_ovf", 8'h16, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h0);
        run_div("remu", 8'h17, 32'd100, 32'd7, 33, 32'd2);
    endtask

    task automatic test_div_reset();
        int stalls = 0;
        bit got = 1'b0;
        @(posedge clk); #1;
        drive(3'd5, 8'h14, 32'hFFFF_FFF9, 32'h2); wreg_i = 1'b1;
        repeat (10) @(posedge clk);
        #1; rst = 1'b1; #1;
        checks++; if (stallreq_o !== 1'b0 || wdata_o !== 32'd0 || wreg_o !== 1'b0) begin
            errors++; $display("FAIL div_rst_out got=%b/%h/%b exp=0/0/0", stallreq_o, wdata_o, wreg_o); end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 100; c++) begin
            #3;
            if (stallreq_o === 1'b1) begin
                stalls++;
                @(posedge clk); #1;
            end else begin
                got = 1'b1;
                break;
            end
        end
        checks++; if (!got || stalls != 33) begin errors++; $display("FAIL div_rst_restart got=%0d exp=33", stalls); end
        checks++; if (wdata_o !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_rst_data got=%h exp=fffffffd", wdata_o); end
        @(posedge clk); #1;
        drive(3'd0, 8'h00, 32'h0, 32'h0);
    endtask
`else
    task automatic test_div_disabled();
        drive(3'd5, 8'h14, 32'hFFFF_FFF9, 32'h2); wreg_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            checks++; if (stallreq_o !== 1'b0 || wreg_o !== 1'b0 || wdata_o !== 32'd0) begin
                errors++; $display("FAIL div_off c%0d got=%b/%b/%h exp=0/0/0", c, stallreq_o, wreg_o, wdata_o); end
        end
        drive(3'd0, 8'h00, 32'h0, 32'h0);
    endtask
`endif

    initial begin
        test_reset();
        test_arith();
        test_logic_shift();
        test_mul();
        test_branch_jump_mem();
`ifdef EX_DIV_EN
        test_div();
        test_div_reset();
`else
        test_div_disabled();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
